cacheline_burst_adaptor: RTL and testbench

- Initiator side of the physical-memory burst interface. Converts one 256-bit cacheline read or write request from the cache arbiter into a 4-beat, 64-bit burst toward physical memory (the parameterised burst memory model in simulation).
- Sits between the arbiter's pmem port and the top-level mem interface.
- Also keeps transaction counters and a sticky protocol-error flag for the bench's performance report.

---
 rtl/burst_pkg.sv | 25 ++
 rtl/cacheline_burst_adaptor.sv | 125 ++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared burst geometry, state encoding and address helper
// Purpose: constants and types used by the cacheline burst adaptor.
// Ports: none (package).
package burst_pkg;

    localparam int BEATS    = 4;
    localparam int BEAT_W   = 64;
    localparam int LINE_W   = BEATS * BEAT_W;
    localparam int OFFSET_W = 5;

    typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

    // Clears the byte-offset bits so every burst starts on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << OFFSET_W) - 32'd1);
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - splits 256-bit line requests into 4x64-bit memory bursts
// Purpose: initiator side of the physical-memory burst interface, with line
//          read/write counters and a sticky protocol-error flag.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   line_read_i/line_write_i  arbiter line requests, held until line_resp_o
//   line_addr_i/line_wdata_i  request byte address and write line
//   line_rdata_o/line_resp_o  assembled read line and one-cycle completion pulse
//   burst_addr_o              line-aligned burst address
//   burst_read_o/burst_write_o burst requests toward memory
//   burst_wdata_o             current write beat
//   burst_rdata_i/burst_resp_i read beat and per-beat handshake from memory
//   read_count_o/write_count_o completed line transactions (wrap mod 2^32)
//   proto_err_o               sticky protocol error
module cacheline_burst_adaptor
    import burst_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [31:0]       line_addr_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [31:0]       burst_addr_o,
    output logic              burst_read_o,
    output logic              burst_write_o,
    output logic [BEAT_W-1:0] burst_wdata_o,
    input  logic [BEAT_W-1:0] burst_rdata_i,
    input  logic              burst_resp_i,
    output logic [31:0]       read_count_o,
    output logic [31:0]       write_count_o,
    output logic              proto_err_o
);

    adaptor_state_t    state;
    beat_idx_t         cnt;
    logic [LINE_W-1:0] wline;
    logic              was_read;

    logic last_beat;
    assign last_beat = (cnt == beat_idx_t'(BEATS - 1));

    // Write beats come straight from the latched line so the data tracks cnt
    // in the same cycle the memory accepts the previous beat.
    assign burst_wdata_o = wline[int'(cnt)*BEAT_W +: BEAT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            wline         <= '0;
            was_read      <= 1'b0;
            line_rdata_o  <= '0;
            line_resp_o   <= 1'b0;
            burst_addr_o  <= '0;
            burst_read_o  <= 1'b0;
            burst_write_o <= 1'b0;
            read_count_o  <= '0;
            write_count_o <= '0;
            proto_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (burst_resp_i || (line_read_i && line_write_i))
                        proto_err_o <= 1'b1;
                    // A colliding write stays pending; it is taken on a later
                    // IDLE cycle if the arbiter still holds it.
                    if (line_read_i) begin
                        burst_addr_o <= line_align(line_addr_i);
                        burst_read_o <= 1'b1;
                        was_read     <= 1'b1;
                        state        <= READ;
                    end else if (line_write_i) begin
                        burst_addr_o  <= line_align(line_addr_i);
                        wline         <= line_wdata_i;
                        burst_write_o <= 1'b1;
                        was_read      <= 1'b0;
                        state         <= WRITE;
                    end
                end
                READ: begin
                    if (burst_resp_i) begin
                        line_rdata_o[int'(cnt)*BEAT_W +: BEAT_W] <= burst_rdata_i;
                        if (last_beat) begin
                            cnt          <= '0;
                            burst_read_o <= 1'b0;
                            line_resp_o  <= 1'b1;
                            state        <= DONE;
                        end else begin
                            cnt <= cnt + beat_idx_t'(1);
                        end
                    end
                end
                WRITE: begin
                    if (burst_resp_i) begin
                        if (last_beat) begin
                            cnt           <= '0;
                            burst_write_o <= 1'b0;
                            line_resp_o   <= 1'b1;
                            state         <= DONE;
                        end else begin
                            cnt <= cnt + beat_idx_t'(1);
                        end
                    end
                end
                DONE: begin
                    // Requests are ignored here so a still-held request is
                    // not mistaken for a new one.
                    if (burst_resp_i)
                        proto_err_o <= 1'b1;
                    line_resp_o <= 1'b0;
                    if (was_read)
                        read_count_o <= read_count_o + 32'd1;
                    else
                        write_count_o <= write_count_o + 32'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb/tb_cacheline_burst_adaptor.sv - randomized self-checking bench for cacheline_burst_adaptor
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         line_read_i = 1'b0;
    logic         line_write_i = 1'b0;
    logic [31:0]  line_addr_i = '0;
    logic [255:0] line_wdata_i = '0;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic [31:0]  burst_addr_o;
    logic         burst_read_o;
    logic         burst_write_o;
    logic [63:0]  burst_wdata_o;
    logic [63:0]  burst_rdata_i = '0;
    logic         burst_resp_i = 1'b0;
    logic [31:0]  read_count_o;
    logic [31:0]  write_count_o;
    logic         proto_err_o;

    cacheline_burst_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .line_read_i  (line_read_i),
        .line_write_i (line_write_i),
        .line_addr_i  (line_addr_i),
        .line_wdata_i (line_wdata_i),
        .line_rdata_o (line_rdata_o),
        .line_resp_o  (line_resp_o),
        .burst_addr_o (burst_addr_o),
        .burst_read_o (burst_read_o),
        .burst_write_o(burst_write_o),
        .burst_wdata_o(burst_wdata_o),
        .burst_rdata_i(burst_rdata_i),
        .burst_resp_i (burst_resp_i),
        .read_count_o (read_count_o),
        .write_count_o(write_count_o),
        .proto_err_o  (proto_err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction-level expectations only.
    logic [31:0] exp_rd_cnt = 0;
    logic [31:0] exp_wr_cnt = 0;
    logic        exp_err    = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [31:0] aligned(input logic [31:0] a);
        return (a / 32) * 32;
    endfunction

    function automatic logic [63:0] beat_of(input logic [255:0] l, input int b);
        return 64'(l >> (64 * b));
    endfunction

    task automatic check_idle_tail(input string tag);
        check({tag, "_resp_low"}, line_resp_o, 1'b0);
        check({tag, "_rd_low"}, burst_read_o, 1'b0);
        check({tag, "_wr_low"}, burst_write_o, 1'b0);
        check({tag, "_rcnt"}, read_count_o, exp_rd_cnt);
        check({tag, "_wcnt"}, write_count_o, exp_wr_cnt);
        check({tag, "_err"}, proto_err_o, exp_err);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input int gmin, input int gmax, input bit with_write);
        logic [31:0] ea;
        ea = aligned(addr);
        line_read_i = 1'b1;
        line_addr_i = addr;
        if (with_write) begin
            line_write_i = 1'b1;
            exp_err = 1'b1;
        end
        step();
        check("rd_start", burst_read_o, 1'b1);
        check("rd_no_wr", burst_write_o, 1'b0);
        check("rd_addr", burst_addr_o, ea);
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(gmax, gmin)) begin
                line_addr_i = $urandom;
                step();
                check("rd_hold", burst_read_o, 1'b1);
                check("rd_addr_hold", burst_addr_o, ea);
                check("rd_no_early_resp", line_resp_o, 1'b0);
            end
            burst_resp_i  = 1'b1;
            burst_rdata_i = beat_of(line, b);
            step();
            burst_resp_i  = 1'b0;
            burst_rdata_i = {$urandom, $urandom};
            if (b < 3) check("rd_mid_resp", line_resp_o, 1'b0);
        end
        check("rd_done_resp", line_resp_o, 1'b1);
        check("rd_line", line_rdata_o, line);
        check("rd_done_req_low", burst_read_o, 1'b0);
        line_read_i = 1'b0;
        exp_rd_cnt++;
        step();
        check_idle_tail("rd_end");
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int gmin, input int gmax);
        logic [31:0] ea;
        ea = aligned(addr);
        line_write_i = 1'b1;
        line_addr_i  = addr;
        line_wdata_i = line;
        step();
        check("wr_start", burst_write_o, 1'b1);
        check("wr_no_rd", burst_read_o, 1'b0);
        check("wr_addr", burst_addr_o, ea);
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(gmax, gmin)) begin
                line_addr_i  = $urandom;
                line_wdata_i = rand_line();
                step();
                check("wr_hold", burst_write_o, 1'b1);
                check("wr_gap_beat", burst_wdata_o, beat_of(line, b));
                check("wr_no_early_resp", line_resp_o, 1'b0);
            end
            check("wr_beat", burst_wdata_o, beat_of(line, b));
            burst_resp_i = 1'b1;
            step();
            burst_resp_i = 1'b0;
        end
        check("wr_done_resp", line_resp_o, 1'b1);
        check("wr_done_req_low", burst_write_o, 1'b0);
        line_write_i = 1'b0;
        exp_wr_cnt++;
        step();
        check_idle_tail("wr_end");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        exp_err    = 0;
        check("rst_rdata", line_rdata_o, 256'd0);
        check("rst_addr", burst_addr_o, 32'd0);
        check_idle_tail("rst");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        do_reset();
        check("rst_wdata", burst_wdata_o, 64'd0);

        // Directed read, back-to-back beats.
        do_read(32'h0000_0044,
                {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 0, 1'b0);
        check("rd1_count", read_count_o, 32'd1);

        // Directed write.
        do_write(32'h0000_1FE0,
                 {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 0, 0);
        check("wr1_count", write_count_o, 32'd1);

        // Read with 3-cycle gaps between beats.
        do_read(32'h0000_0044,
                {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 3, 3, 1'b0);

        // Stray beat in IDLE.
        burst_resp_i = 1'b1;
        step();
        burst_resp_i = 1'b0;
        exp_err = 1'b1;
        check_idle_tail("idle_resp");
        step();
        check_idle_tail("idle_resp_sticky");

        // Collision: read wins, write follows.
        do_reset();
        do_read($urandom, rand_line(), 0, 2, 1'b1);
        do_write($urandom, rand_line(), 0, 2);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(1, 0) == 1)
                do_read($urandom, rand_line(), 0, 3, 1'b0);
            else
                do_write($urandom, rand_line(), 0, 3);
        end

        // Reset after two read beats.
        line_read_i = 1'b1;
        line_addr_i = $urandom;
        step();
        for (int b = 0; b < 2; b++) begin
            burst_resp_i  = 1'b1;
            burst_rdata_i = {$urandom | 32'h1, $urandom};
            step();
        end
        burst_resp_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        line_read_i = 1'b0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        exp_err    = 0;
        check("mid_rst_rdata", line_rdata_o, 256'd0);
        check_idle_tail("mid_rst");
        step();
        check_idle_tail("mid_rst_after");

        do_read($urandom, rand_line(), 0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
